multicycle_ctrl: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle MIPS control decoder.
- An FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the same datapath control set (RegWrite, MemWrite, EXTOp, ALUOp, NPCOp, ALUSrc, GPRSel, WDSel).
- Adds a ready/request memory handshake, an illegal-opcode trap with a selectable mode, and a retired-instruction counter.
- Sits between the IR and the shared-memory multi-cycle datapath.

---
 rtl/multicycle_ctrl_if.sv | 39 +++
 rtl/multicycle_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - IR/datapath/memory signal bundle for the multi-cycle controller
interface multicycle_ctrl_if #(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 32
);
  // IR fields, ALU flag and memory handshake into the controller
  logic [5:0]         Op;
  logic [5:0]         Funct;
  logic               Zero;
  logic               mem_ready;

  // Datapath and memory control out of the controller
  logic               mem_req;
  logic               IorD;
  logic               IRWrite;
  logic               PCWrite;
  logic               RegWrite;
  logic               MemWrite;
  logic               EXTOp;
  logic               ALUSrc;
  logic [ALUOP_W-1:0] ALUOp;
  logic [1:0]         NPCOp;
  logic [1:0]         GPRSel;
  logic [1:0]         WDSel;
  logic               halted;
  logic [CNT_W-1:0]   instret;

  modport master (
    input  Op, Funct, Zero, mem_ready,
    output mem_req, IorD, IRWrite, PCWrite, RegWrite, MemWrite, EXTOp, ALUSrc,
           ALUOp, NPCOp, GPRSel, WDSel, halted, instret
  );

  modport slave (
    output Op, Funct, Zero, mem_ready,
    input  mem_req, IorD, IRWrite, PCWrite, RegWrite, MemWrite, EXTOp, ALUSrc,
           ALUOp, NPCOp, GPRSel, WDSel, halted, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control FSM with memory handshake, trap and retire counter
module multicycle_ctrl #(
  parameter int ALUOP_W         = 4,
  parameter int CNT_W           = 32,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic             clk,
  input  logic             rstn,
  multicycle_ctrl_if.master bus
);

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd8;

  localparam logic [1:0] NPC_PLUS4  = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JR     = 2'd3;

  localparam logic [1:0] GPR_RD  = 2'd0;
  localparam logic [1:0] GPR_RT  = 2'd1;
  localparam logic [1:0] GPR_R31 = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB_ALU, S_WB_MEM, S_TRAP
  } state_t;

  // Instruction class: picks the EXEC/MEM/WB path through the FSM
  typedef enum logic [3:0] {
    C_NONE, C_RALU, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_JALR
  } iclass_t;

  state_t           state, state_next;
  iclass_t          cls;
  logic [3:0]       dec_alu;
  logic             dec_src;
  logic             dec_ext;
  logic             legal;
  logic             retire;
  logic [CNT_W-1:0] instret_q;

  logic             mem_req, iord, ir_write, pc_write, reg_write, mem_write;
  logic             ext_op, alu_src, halted;
  logic [3:0]       alu_op;
  logic [1:0]       npc_op, gpr_sel, wd_sel;

  // Opcode/funct decode into instruction class and per-instruction ALU controls
  always_comb begin
    cls     = C_NONE;
    dec_alu = ALU_NOP;
    dec_src = 1'b0;
    dec_ext = 1'b0;
    case (bus.Op)
      6'h00: begin
        case (bus.Funct)
          6'h20, 6'h21: begin cls = C_RALU; dec_alu = ALU_ADD;  end
          6'h22, 6'h23: begin cls = C_RALU; dec_alu = ALU_SUB;  end
          6'h24:        begin cls = C_RALU; dec_alu = ALU_AND;  end
          6'h25:        begin cls = C_RALU; dec_alu = ALU_OR;   end
          6'h27:        begin cls = C_RALU; dec_alu = ALU_NOR;  end
          6'h2A:        begin cls = C_RALU; dec_alu = ALU_SLT;  end
          6'h2B:        begin cls = C_RALU; dec_alu = ALU_SLTU; end
          6'h08:        cls = C_JR;
          6'h09:        cls = C_JALR;
          default:      cls = C_NONE;
        endcase
      end
      6'h08: begin cls = C_IALU; dec_alu = ALU_ADD; dec_src = 1'b1; dec_ext = 1'b1; end
      6'h0C: begin cls = C_IALU; dec_alu = ALU_AND; dec_src = 1'b1; end
      6'h0D: begin cls = C_IALU; dec_alu = ALU_OR;  dec_src = 1'b1; end
      6'h0A: begin cls = C_IALU; dec_alu = ALU_SLT; dec_src = 1'b1; dec_ext = 1'b1; end
      6'h23: begin cls = C_LW;   dec_alu = ALU_ADD; dec_src = 1'b1; dec_ext = 1'b1; end
      6'h2B: begin cls = C_SW;   dec_alu = ALU_ADD; dec_src = 1'b1; dec_ext = 1'b1; end
      6'h04: begin cls = C_BEQ;  dec_alu = ALU_SUB; dec_ext = 1'b1; end
      6'h05: begin cls = C_BNE;  dec_alu = ALU_SUB; dec_ext = 1'b1; end
      6'h02: cls = C_J;
      6'h03: cls = C_JAL;
      default: cls = C_NONE;
    endcase
    legal = (cls != C_NONE);
  end

  // State register; reset drops straight to IDLE so no strobe survives a mid-instruction reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state and control outputs per state; Zero and mem_ready only matter where consumed
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    ext_op     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_NOP;
    npc_op     = NPC_PLUS4;
    gpr_sel    = GPR_RD;
    wd_sel     = WD_ALU;
    halted     = 1'b0;
    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          npc_op     = NPC_PLUS4;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (legal)                     state_next = S_EXEC;
        else if (HALT_ON_ILLEGAL != 0) state_next = S_TRAP;
        else                           state_next = S_FETCH;
      end
      S_EXEC: begin
        alu_op  = dec_alu;
        alu_src = dec_src;
        ext_op  = dec_ext;
        case (cls)
          C_RALU, C_IALU: state_next = S_WB_ALU;
          C_LW, C_SW:     state_next = S_MEM;
          C_BEQ: begin
            pc_write = bus.Zero; npc_op = NPC_BRANCH; state_next = S_FETCH;
          end
          C_BNE: begin
            pc_write = ~bus.Zero; npc_op = NPC_BRANCH; state_next = S_FETCH;
          end
          C_J: begin
            pc_write = 1'b1; npc_op = NPC_JUMP; state_next = S_FETCH;
          end
          C_JAL: begin
            pc_write  = 1'b1; npc_op = NPC_JUMP;
            reg_write = 1'b1; gpr_sel = GPR_R31; wd_sel = WD_PC;
            state_next = S_FETCH;
          end
          C_JR: begin
            pc_write = 1'b1; npc_op = NPC_JR; state_next = S_FETCH;
          end
          C_JALR: begin
            pc_write  = 1'b1; npc_op = NPC_JR;
            reg_write = 1'b1; gpr_sel = GPR_RD; wd_sel = WD_PC;
            state_next = S_FETCH;
          end
          default: state_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = (cls == C_SW);
        alu_op    = ALU_ADD;
        alu_src   = 1'b1;
        ext_op    = 1'b1;
        if (bus.mem_ready) state_next = (cls == C_SW) ? S_FETCH : S_WB_MEM;
      end
      S_WB_ALU: begin
        reg_write  = 1'b1;
        wd_sel     = WD_ALU;
        gpr_sel    = (cls == C_RALU) ? GPR_RD : GPR_RT;
        state_next = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        wd_sel     = WD_MEM;
        gpr_sel    = GPR_RT;
        state_next = S_FETCH;
      end
      S_TRAP: halted = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end

  // Retirement is any return to FETCH except the initial one out of IDLE
  assign retire = (state_next == S_FETCH) && (state != S_IDLE) && (state != S_FETCH);

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       instret_q <= '0;
    else if (retire) instret_q <= instret_q + CNT_W'(1);
  end

  assign bus.mem_req  = mem_req;
  assign bus.IorD     = iord;
  assign bus.IRWrite  = ir_write;
  assign bus.PCWrite  = pc_write;
  assign bus.RegWrite = reg_write;
  assign bus.MemWrite = mem_write;
  assign bus.EXTOp    = ext_op;
  assign bus.ALUSrc   = alu_src;
  assign bus.ALUOp    = ALUOP_W'(alu_op);
  assign bus.NPCOp    = npc_op;
  assign bus.GPRSel   = gpr_sel;
  assign bus.WDSel    = wd_sel;
  assign bus.halted   = halted;
  assign bus.instret  = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed table-driven bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic clk;
  logic rstn_a;
  logic rstn_b;

  multicycle_ctrl_if #(.ALUOP_W(4), .CNT_W(32)) if_a ();
  multicycle_ctrl_if #(.ALUOP_W(4), .CNT_W(4))  if_b ();

  multicycle_ctrl #(.ALUOP_W(4), .CNT_W(32), .HALT_ON_ILLEGAL(1)) dut_a (
    .clk (clk), .rstn(rstn_a), .bus(if_a.master)
  );

  multicycle_ctrl #(.ALUOP_W(4), .CNT_W(4), .HALT_ON_ILLEGAL(0)) dut_b (
    .clk (clk), .rstn(rstn_b), .bus(if_b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    int          cycles;
    logic [15:0] exec_exp;
    logic [5:0]  last_exp;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] ex(input logic pcw, input logic [1:0] npc, input logic rw,
                                     input logic [1:0] g, input logic [1:0] w, input logic [3:0] alu,
                                     input logic src, input logic ext);
    return {pcw, npc, rw, g, w, alu, src, ext, 1'b0, 1'b0};
  endfunction

  function automatic logic [5:0] lb(input logic rw, input logic [1:0] g, input logic [1:0] w,
                                    input logic mw);
    return {rw, g, w, mw};
  endfunction

  function automatic logic [15:0] exec_a();
    return {if_a.PCWrite, if_a.NPCOp, if_a.RegWrite, if_a.GPRSel, if_a.WDSel, if_a.ALUOp[3:0],
            if_a.ALUSrc, if_a.EXTOp, if_a.MemWrite, if_a.mem_req};
  endfunction

  function automatic logic [5:0] last_a();
    return {if_a.RegWrite, if_a.GPRSel, if_a.WDSel, if_a.MemWrite};
  endfunction

  function automatic logic [18:0] outs_a();
    return {if_a.mem_req, if_a.IorD, if_a.IRWrite, if_a.PCWrite, if_a.RegWrite, if_a.MemWrite,
            if_a.EXTOp, if_a.ALUSrc, if_a.ALUOp[3:0], if_a.NPCOp, if_a.GPRSel, if_a.WDSel, if_a.halted};
  endfunction

  function automatic logic [18:0] outs_b();
    return {if_b.mem_req, if_b.IorD, if_b.IRWrite, if_b.PCWrite, if_b.RegWrite, if_b.MemWrite,
            if_b.EXTOp, if_b.ALUSrc, if_b.ALUOp[3:0], if_b.NPCOp, if_b.GPRSel, if_b.WDSel, if_b.halted};
  endfunction

  // Entry and exit: just after a falling edge with dut_a in FETCH
  task automatic run_vec(input vec_t v);
    int base;
    int cycles;
    logic [15:0] exb;
    logic [5:0] lst;
    base = int'(if_a.instret);
    if_a.Op = v.op; if_a.Funct = v.funct; if_a.Zero = v.zero; if_a.mem_ready = 1'b1;
    #1;
    check({v.name, "_fetch"}, 32'({if_a.IRWrite, if_a.PCWrite, if_a.NPCOp, if_a.mem_req, if_a.IorD}),
          32'(6'b110010));
    @(negedge clk); #1;
    check({v.name, "_decode"}, 32'({if_a.IRWrite, if_a.PCWrite, if_a.RegWrite, if_a.MemWrite,
          if_a.mem_req, if_a.halted, if_a.ALUOp}), 32'd0);
    @(negedge clk); #1;
    exb = exec_a();
    lst = last_a();
    cycles = 3;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); #1;
      if (if_a.mem_req && !if_a.IorD) break;
      cycles++;
      lst = last_a();
    end
    check({v.name, "_exec"}, 32'(exb), 32'(v.exec_exp));
    check({v.name, "_last"}, 32'(lst), 32'(v.last_exp));
    check({v.name, "_cycles"}, 32'(cycles), 32'(v.cycles));
    check({v.name, "_instret"}, if_a.instret, 32'(base + 1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int bad;
    int cycles;

    vq.push_back('{"add",   6'h00, 6'h20, 1'b0, 4, ex(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 4'd1, 1'b0, 1'b0), lb(1'b1, 2'd0, 2'd0, 1'b0)});
    vq.push_back('{"addu",  6'h00, 6'h21, 1'b0, 4, ex(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 4'd1, 1'b0, 1'b0), lb(1'b1, 2'd0, 2'd0, 1'b0)});
    vq.push_back('{"sub",   6'h00, 6'h22, 1'b0, 4, ex(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 4'd2, 1'b0, 1'b0), lb(1'b1, 2'd0, 2'd0, 1'b0)});
    vq.push_back('{"subu",  6'h00, 6'h23, 1'b0, 4, ex(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 4'd2, 1'b0, 1'b0), lb(1'b1, 2'd0, 2'd0, 1'b0)});
    vq.push_back('{"and",   6'h00, 6'h24, 1'b0, 4, ex(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 4'd3, 1'b0, 1'b0), lb(1'b1, 2'd0, 2'd0, 1'b0)});
    vq.push_back('{"or",    6'h00, 6'h25, 1'b0, 4, ex(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 4'd4, 1'b0, 1'b0), lb(1'b1, 2'd0, 2'd0, 1'b0)});
    vq.push_back('{"nor",   6'h00, 6'h27, 1'b0, 4, ex(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 4'd8, 1'b0, 1'b0), lb(1'b1, 2'd0, 2'd0, 1'b0)});
    vq.push_back('{"slt",   6'h00, 6'h2A, 1'b0, 4, ex(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 4'd5, 1'b0, 1'b0), lb(1'b1, 2'd0, 2'd0, 1'b0)});
    vq.push_back('{"sltu",  6'h00, 6'h2B, 1'b0, 4, ex(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 4'd6, 1'b0, 1'b0), lb(1'b1, 2'd0, 2'd0, 1'b0)});
    vq.push_back('{"addi",  6'h08, 6'h00, 1'b0, 4, ex(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 4'd1, 1'b1, 1'b1), lb(1'b1, 2'd1, 2'd0, 1'b0)});
    vq.push_back('{"andi",  6'h0C, 6'h00, 1'b0, 4, ex(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 4'd3, 1'b1, 1'b0), lb(1'b1, 2'd1, 2'd0, 1'b0)});
    vq.push_back('{"ori",   6'h0D, 6'h00, 1'b0, 4, ex(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 4'd4, 1'b1, 1'b0), lb(1'b1, 2'd1, 2'd0, 1'b0)});
    vq.push_back('{"slti",  6'h0A, 6'h00, 1'b0, 4, ex(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 4'd5, 1'b1, 1'b1), lb(1'b1, 2'd1, 2'd0, 1'b0)});
    vq.push_back('{"lw",    6'h23, 6'h00, 1'b0, 5, ex(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 4'd1, 1'b1, 1'b1), lb(1'b1, 2'd1, 2'd1, 1'b0)});
    vq.push_back('{"sw",    6'h2B, 6'h00, 1'b0, 4, ex(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 4'd1, 1'b1, 1'b1), lb(1'b0, 2'd0, 2'd0, 1'b1)});
    vq.push_back('{"beq_z1", 6'h04, 6'h00, 1'b1, 3, ex(1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 4'd2, 1'b0, 1'b1), lb(1'b0, 2'd0, 2'd0, 1'b0)});
    vq.push_back('{"beq_z0", 6'h04, 6'h00, 1'b0, 3, ex(1'b0, 2'd1, 1'b0, 2'd0, 2'd0, 4'd2, 1'b0, 1'b1), lb(1'b0, 2'd0, 2'd0, 1'b0)});
    vq.push_back('{"bne_z0", 6'h05, 6'h00, 1'b0, 3, ex(1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 4'd2, 1'b0, 1'b1), lb(1'b0, 2'd0, 2'd0, 1'b0)});
    vq.push_back('{"bne_z1", 6'h05, 6'h00, 1'b1, 3, ex(1'b0, 2'd1, 1'b0, 2'd0, 2'd0, 4'd2, 1'b0, 1'b1), lb(1'b0, 2'd0, 2'd0, 1'b0)});
    vq.push_back('{"j",     6'h02, 6'h00, 1'b0, 3, ex(1'b1, 2'd2, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0), lb(1'b0, 2'd0, 2'd0, 1'b0)});
    vq.push_back('{"jal",   6'h03, 6'h00, 1'b0, 3, ex(1'b1, 2'd2, 1'b1, 2'd2, 2'd2, 4'd0, 1'b0, 1'b0), lb(1'b1, 2'd2, 2'd2, 1'b0)});
    vq.push_back('{"jr",    6'h00, 6'h08, 1'b0, 3, ex(1'b1, 2'd3, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0), lb(1'b0, 2'd0, 2'd0, 1'b0)});
    vq.push_back('{"jalr",  6'h00, 6'h09, 1'b0, 3, ex(1'b1, 2'd3, 1'b1, 2'd0, 2'd2, 4'd0, 1'b0, 1'b0), lb(1'b1, 2'd0, 2'd2, 1'b0)});

    // Both controllers held in reset with arbitrary inputs on dut_a
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    if_b.Op = 6'h3F; if_b.Funct = 6'h00; if_b.Zero = 1'b0; if_b.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if_a.Op = 6'($urandom); if_a.Funct = 6'($urandom);
      if_a.Zero = 1'($urandom); if_a.mem_ready = 1'($urandom);
      #1;
      check("reset_outs", 32'(outs_a()), 32'd0);
      check("reset_instret", if_a.instret, 32'd0);
    end

    // Release: one IDLE cycle, then FETCH stalled on mem_ready=0
    @(negedge clk);
    rstn_a = 1'b1;
    if_a.Op = 6'h00; if_a.Funct = 6'h20; if_a.Zero = 1'b0; if_a.mem_ready = 1'b0;
    #1;
    check("idle_outs", 32'(outs_a()), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check("fetch_wait", 32'({if_a.mem_req, if_a.IorD, if_a.IRWrite, if_a.PCWrite, if_a.RegWrite}),
            32'(5'b10000));
    end
    check("fetch_wait_instret", if_a.instret, 32'd0);

    foreach (vq[i]) run_vec(vq[i]);

    // lw with three wait cycles in MEM
    base = int'(if_a.instret);
    if_a.Op = 6'h23; if_a.Funct = 6'h00; if_a.mem_ready = 1'b1;
    #1;
    cycles = 1;
    @(negedge clk); #1; cycles++;
    @(negedge clk); if_a.mem_ready = 1'b0; #1; cycles++;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if_a.mem_ready = (k == 3);
      #1;
      cycles++;
      if (!(if_a.mem_req && if_a.IorD && !if_a.RegWrite && !if_a.MemWrite)) bad++;
    end
    check("lw_wait_mem", 32'(bad), 32'd0);
    @(negedge clk); #1; cycles++;
    check("lw_wait_wb", 32'({if_a.RegWrite, if_a.WDSel, if_a.GPRSel}), 32'(5'b10101));
    @(negedge clk); #1;
    check("lw_wait_fetch", 32'({if_a.mem_req, if_a.IorD}), 32'(2'b10));
    check("lw_wait_cycles", 32'(cycles), 32'd8);
    check("lw_wait_instret", if_a.instret, 32'(base + 1));

    // Reset while a sw request is pending in MEM
    if_a.Op = 6'h2B; if_a.mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); if_a.mem_ready = 1'b0;
    @(negedge clk); #1;
    check("sw_mem_pending", 32'({if_a.mem_req, if_a.IorD, if_a.MemWrite}), 32'(3'b111));
    rstn_a = 1'b0;
    #1;
    check("midreset_outs", 32'(outs_a()), 32'd0);
    check("midreset_instret", if_a.instret, 32'd0);
    @(negedge clk);
    rstn_a = 1'b1;
    @(negedge clk); #1;
    check("midreset_refetch", 32'({if_a.mem_req, if_a.IorD}), 32'(2'b10));

    // Illegal opcode traps and stays trapped despite mem_ready
    if_a.Op = 6'h3F; if_a.mem_ready = 1'b1;
    @(negedge clk);
    base = int'(if_a.instret);
    @(negedge clk); #1;
    check("trap_outs", 32'(outs_a()), 32'd1);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (outs_a() != 19'd1) bad++;
    end
    check("trap_sticky", 32'(bad), 32'd0);
    check("trap_instret", if_a.instret, 32'(base));

    // Illegal-as-NOP controller with a 4-bit counter wraps after 16 retirements
    @(negedge clk);
    rstn_b = 1'b1;
    #1;
    check("b_idle_outs", 32'(outs_b()), 32'd0);
    @(negedge clk); #1;
    check("b_fetch", 32'({if_b.mem_req, if_b.IorD, if_b.instret}), 32'({2'b10, 4'd0}));
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      @(negedge clk); #1;
      if (i == 1)  check("b_instret_1", 32'(if_b.instret), 32'd1);
      if (i == 15) check("b_instret_15", 32'(if_b.instret), 32'd15);
      if (i == 16) check("b_instret_wrap", 32'(if_b.instret), 32'd0);
    end
    check("b_not_halted", 32'({if_b.halted, if_b.mem_req}), 32'(2'b01));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
